// File: rtl/tcm_ber_chk.sv
// rtl/tcm_ber_chk.sv - PRBS-23 bit-error-rate checker for TCM decoder words
// Optional word-count check against pN: define TCM_BER_CHK_LEN_CHK_EN.

module tcm_ber_chk #(
    parameter int          pN     = 1000,
    parameter int          pCNT_W = 32,
    parameter logic [22:0] pSEED  = 23'h7FFFFF
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic [1:0]        icode,
    input  logic              iclear,
    input  logic              isop,
    input  logic              ival,
    input  logic              ieop,
    input  logic [10:0]       idat,
    output logic              oval,
    output logic [15:0]       opkt_err,
    output logic [pCNT_W-1:0] obit_cnt,
    output logic [pCNT_W-1:0] oerr_cnt,
    output logic [pCNT_W-1:0] ofrm_cnt,
    output logic [pCNT_W-1:0] ofrm_err_cnt,
    output logic              osop_err,
    output logic              olen_err
);

    typedef enum logic {IDLE, PKT} state_t;

    state_t              state;
    logic [22:0]         lfsr;
    logic [1:0]          code_q;
    logic [15:0]         acc;
    logic [pCNT_W-1:0]   wcnt;
    logic                pend;
    logic [15:0]         pend_err;
    logic [pCNT_W+3:0]   pend_bits;
    logic                pend_bad;
`ifdef TCM_BER_CHK_LEN_CHK_EN
    logic                pend_len;
`endif

    logic                start, accept, done, proto_err, len_bad;
    logic [1:0]          code_cur;
    logic [22:0]         lfsr_base, lfsr_nxt;
    logic [10:0]         prbs_word, mask;
    logic [3:0]          word_err, nbits;
    logic [16:0]         acc_sum;
    logic [15:0]         acc_nxt;
    logic [pCNT_W-1:0]   wcnt_base, wcnt_nxt;

    // Eleven Fibonacci steps of x^23+x^18+1; bit i of the word is the i-th new bit.
    function automatic logic [33:0] prbs11(input logic [22:0] s);
        logic [22:0] t;
        logic [10:0] w;
        logic        b;
        t = s;
        w = '0;
        for (int i = 0; i < 11; i++) begin
            b    = t[22] ^ t[17];
            w[i] = b;
            t    = {t[21:0], b};
        end
        return {w, t};
    endfunction

    function automatic logic [pCNT_W-1:0] sat_add(input logic [pCNT_W-1:0] a,
                                                  input logic [pCNT_W+3:0] b);
        logic [pCNT_W+4:0] s;
        s = {5'd0, a} + {1'b0, b};
        return (|s[pCNT_W+4:pCNT_W]) ? '1 : s[pCNT_W-1:0];
    endfunction

    always_comb begin
        start     = ival & isop;
        accept    = ival & (isop | (state == PKT));
        done      = accept & ieop;
        proto_err = ival & ((state == IDLE) ? ~isop : isop);
        code_cur  = start ? icode : code_q;
        lfsr_base = start ? pSEED : lfsr;
        {prbs_word, lfsr_nxt} = prbs11(lfsr_base);
        mask = 11'h0FF;
        case (code_cur)
            2'd0: mask = 11'h0FF;
            2'd1: mask = 11'h1FF;
            2'd2: mask = 11'h3FF;
            2'd3: mask = 11'h7FF;
        endcase
        nbits     = 4'd8 + {2'b00, code_cur};
        word_err  = 4'($countones((idat ^ prbs_word) & mask));
        acc_sum   = {1'b0, (start ? 16'd0 : acc)} + {13'd0, word_err};
        acc_nxt   = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
        wcnt_base = start ? '0 : wcnt;
        wcnt_nxt  = (&wcnt_base) ? wcnt_base : wcnt_base + pCNT_W'(1);
`ifdef TCM_BER_CHK_LEN_CHK_EN
        len_bad   = (wcnt_nxt != pCNT_W'(pN));
`else
        len_bad   = 1'b0;
`endif
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state        <= IDLE;
            lfsr         <= pSEED;
            code_q       <= '0;
            acc          <= '0;
            wcnt         <= '0;
            pend         <= 1'b0;
            pend_err     <= '0;
            pend_bits    <= '0;
            pend_bad     <= 1'b0;
            oval         <= 1'b0;
            opkt_err     <= '0;
            obit_cnt     <= '0;
            oerr_cnt     <= '0;
            ofrm_cnt     <= '0;
            ofrm_err_cnt <= '0;
            osop_err     <= 1'b0;
`ifdef TCM_BER_CHK_LEN_CHK_EN
            pend_len     <= 1'b0;
            olen_err     <= 1'b0;
`endif
        end else if (iclkena) begin
            if (accept) begin
                state  <= ieop ? IDLE : PKT;
                lfsr   <= lfsr_nxt;
                code_q <= code_cur;
                acc    <= acc_nxt;
                wcnt   <= wcnt_nxt;
            end
            // Stage 1 captures the finished packet, stage 2 publishes it.
            pend <= done;
            if (done) begin
                pend_err  <= acc_nxt;
                pend_bits <= (pCNT_W+4)'(wcnt_nxt) * (pCNT_W+4)'(nbits);
                pend_bad  <= (acc_nxt != 16'd0) | len_bad;
`ifdef TCM_BER_CHK_LEN_CHK_EN
                pend_len  <= len_bad;
`endif
            end
            oval <= pend;
            if (pend)
                opkt_err <= pend_err;
            if (iclear) begin
                obit_cnt     <= '0;
                oerr_cnt     <= '0;
                ofrm_cnt     <= '0;
                ofrm_err_cnt <= '0;
                osop_err     <= 1'b0;
`ifdef TCM_BER_CHK_LEN_CHK_EN
                olen_err     <= 1'b0;
`endif
            end else begin
                if (pend) begin
                    ofrm_cnt <= sat_add(ofrm_cnt, (pCNT_W+4)'(1));
                    obit_cnt <= sat_add(obit_cnt, pend_bits);
                    oerr_cnt <= sat_add(oerr_cnt, (pCNT_W+4)'(pend_err));
                    if (pend_bad)
                        ofrm_err_cnt <= sat_add(ofrm_err_cnt, (pCNT_W+4)'(1));
                end
                if (proto_err)
                    osop_err <= 1'b1;
`ifdef TCM_BER_CHK_LEN_CHK_EN
                if (pend & pend_len)
                    olen_err <= 1'b1;
`endif
            end
        end
    end

`ifndef TCM_BER_CHK_LEN_CHK_EN
    assign olen_err = 1'b0;
`endif

endmodule

// File: tb/tb_tcm_ber_chk.sv
// tb/tb_tcm_ber_chk.sv - self-checking bench for tcm_ber_chk against a PRBS bit-list model

module tb_tcm_ber_chk;

    localparam int          NW      = 1000;
    localparam logic [22:0] SEED    = 23'h7FFFFF;
    localparam int          SEQ_LEN = 23 + 11 * (NW + 1);

    logic        iclk = 1'b0;
    logic        ireset, iclkena, iclear, isop, ival, ieop;
    logic [1:0]  icode;
    logic [10:0] idat;
    logic        oval, osop_err, olen_err;
    logic [15:0] opkt_err;
    logic [31:0] obit_cnt, oerr_cnt, ofrm_cnt, ofrm_err_cnt;

    tcm_ber_chk #(.pN(NW), .pCNT_W(32), .pSEED(SEED)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .icode(icode),
        .iclear(iclear), .isop(isop), .ival(ival), .ieop(ieop), .idat(idat),
        .oval(oval), .opkt_err(opkt_err), .obit_cnt(obit_cnt), .oerr_cnt(oerr_cnt),
        .ofrm_cnt(ofrm_cnt), .ofrm_err_cnt(ofrm_err_cnt),
        .osop_err(osop_err), .olen_err(olen_err)
    );

    always #5 iclk = ~iclk;

    int          n_tot = 0, n_pass = 0, n_fail = 0;
    longint      exp_frm, exp_bits, exp_err, exp_frm_err;
    bit          exp_sop, exp_len, in_pkt;
    logic [15:0] exp_pkt;
    bit          seq [0:SEQ_LEN-1];
    logic [10:0] ref_word [0:NW];
    logic [10:0] flip [0:NW];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_frm"},     ofrm_cnt,     exp_frm);
        chk({tag, "_bits"},    obit_cnt,     exp_bits);
        chk({tag, "_err"},     oerr_cnt,     exp_err);
        chk({tag, "_frm_err"}, ofrm_err_cnt, exp_frm_err);
        chk({tag, "_sop"},     osop_err,     exp_sop);
        chk({tag, "_len"},     olen_err,     exp_len);
    endtask

    task automatic model_zero();
        exp_frm = 0; exp_bits = 0; exp_err = 0; exp_frm_err = 0;
        exp_sop = 0; exp_len = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            ival = 0; isop = 1'($urandom); ieop = 1'($urandom); idat = 11'($urandom);
            @(posedge iclk); #1;
        end
        isop = 0; ieop = 0;
    endtask

    task automatic set_flips(input logic [10:0] f);
        for (int k = 0; k <= NW; k++) flip[k] = f;
    endtask

    task automatic do_clear();
        iclear = 1; @(posedge iclk); #1; iclear = 0;
        model_zero();
        chk_all("clear");
    endtask

    // Drives one packet of n words; with eop=0 the packet is left open.
    task automatic send_pkt(input int n, input logic [1:0] code, input int post_gap,
                            input bit eop, input bit rnd, input bit clr);
        int errs, nb;
        bit len_bad;
        errs = 0;
        nb = 8 + int'(code);
        for (int k = 0; k < n; k++) begin
            if (rnd) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                if ($urandom_range(0, 5) == 0) begin
                    iclkena = 0; ival = 1; isop = 1'($urandom); ieop = 1'($urandom);
                    iclear = 1'($urandom); idat = 11'($urandom);
                    @(posedge iclk); #1;
                    iclkena = 1; iclear = 0;
                end
            end
            ival = 1; isop = (k == 0); ieop = eop && (k == n - 1);
            icode = (k == 0) ? code : 2'($urandom);
            idat = ref_word[k] ^ flip[k];
            for (int i = 0; i < nb; i++)
                if (idat[i] != ref_word[k][i]) errs++;
            if (k == 0 && in_pkt) exp_sop = 1;
            @(posedge iclk); #1;
        end
        ival = 0; isop = 0; ieop = 0;
        if (!eop) begin
            in_pkt = 1;
            return;
        end
        in_pkt = 0;
`ifdef TCM_BER_CHK_LEN_CHK_EN
        len_bad = (n != NW);
`else
        len_bad = 0;
`endif
        chk("oval_early", oval, 0);
        iclear = clr;
        @(posedge iclk); #1;
        iclear = 0;
        exp_pkt = 16'(errs);
        if (clr) model_zero();
        else begin
            exp_frm++;
            exp_bits += longint'(nb) * n;
            exp_err += errs;
            if (errs != 0 || len_bad) exp_frm_err++;
            if (len_bad) exp_len = 1;
        end
        chk("oval", oval, 1);
        chk("pkt_err", opkt_err, exp_pkt);
        chk_all("pkt");
        @(posedge iclk); #1;
        chk("oval_pulse", oval, 0);
        chk("pkt_err_hold", opkt_err, exp_pkt);
        idle(post_gap);
    endtask

    initial begin
        // Reference PRBS as a bit list: history from the seed, then b[m] = b[m-23] ^ b[m-18].
        for (int j = 0; j < 23; j++) seq[j] = SEED[22-j];
        for (int m = 23; m < SEQ_LEN; m++) seq[m] = seq[m-23] ^ seq[m-18];
        for (int k = 0; k <= NW; k++)
            for (int i = 0; i < 11; i++) ref_word[k][i] = seq[23 + 11*k + i];

        ireset = 0; iclkena = 1; iclear = 0; isop = 0; ival = 0; ieop = 0;
        icode = 0; idat = 0; in_pkt = 0; exp_pkt = 0;
        model_zero();
        set_flips(11'h000);
        repeat (3) @(posedge iclk);
        #1;
        chk("rst_oval", oval, 0);
        chk("rst_pkt", opkt_err, 0);
        chk_all("rst");
        ireset = 1;
        idle(2);

        // Error-free run
        for (int p = 0; p < 3; p++) send_pkt(NW, 2'd0, 1, 1, 0, 0);
        chk("clean_frm", ofrm_cnt, 3);
        chk("clean_bits", obit_cnt, 24000);
        chk("clean_err", oerr_cnt, 0);
        chk("clean_frm_err", ofrm_err_cnt, 0);

        // Error injection at code 3
        do_clear();
        flip[5] = 11'h400; flip[7] = 11'h001;
        send_pkt(NW, 2'd3, 2, 1, 0, 0);
        chk("inj_pkt", opkt_err, 2);
        chk("inj_bits", obit_cnt, 11000);
        chk("inj_frm_err", ofrm_err_cnt, 1);

        // Upper bits masked at code 0
        set_flips(11'h700);
        send_pkt(NW, 2'd0, 2, 1, 0, 0);
        chk("mask_pkt", opkt_err, 0);
        set_flips(11'h000);

        // Stray word in IDLE, then an aborted packet
        do_clear();
        ival = 1; isop = 0; ieop = 1; idat = 11'($urandom);
        @(posedge iclk); #1;
        ival = 0; ieop = 0;
        exp_sop = 1;
        chk_all("stray");
        do_clear();
        send_pkt(10, 2'd2, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge iclk); #1;
            chk("abort_no_oval", oval, 0);
        end
        send_pkt(NW, 2'd1, 2, 1, 0, 0);
        chk("abort_sop", osop_err, 1);
        chk("abort_frm", ofrm_cnt, 1);

`ifdef TCM_BER_CHK_LEN_CHK_EN
        do_clear();
        send_pkt(NW - 1, 2'd0, 2, 1, 0, 0);
        chk("len_flag", olen_err, 1);
        chk("len_frm_err", ofrm_err_cnt, 1);
`endif

        // Randomized short packets with gaps, freezes and random corruption
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k <= NW; k++)
                flip[k] = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'h000;
            send_pkt($urandom_range(1, 40), 2'($urandom), $urandom_range(0, 3), 1, 1, 0);
        end
        set_flips(11'h000);

        // Reset mid-packet
        send_pkt(20, 2'd1, 0, 0, 0, 0);
        ireset = 0; #1;
        model_zero(); in_pkt = 0; exp_pkt = 0;
        chk("arst_oval", oval, 0);
        chk("arst_pkt", opkt_err, 0);
        chk_all("arst");
        @(posedge iclk); #1;
        ireset = 1;
        ival = 1; isop = 0; ieop = 0; idat = ref_word[20];
        repeat (2) begin @(posedge iclk); #1; end
        ival = 0;
        exp_sop = 1;
        chk_all("post_rst");
        send_pkt(30, 2'd2, 2, 1, 1, 0);

        // Clear coincident with the counter update
        flip[3] = 11'h005;
        send_pkt(25, 2'd3, 2, 1, 0, 1);
        chk("clr_oval_pkt", opkt_err, 2);
        chk("clr_oval_frm", ofrm_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
